// File: rtl/fetch_pc_unit.sv
// MIPS instruction-fetch stage: PC register, IF/ID register and a one-outstanding imem handshake.
// Optional PC_ALIGN_CHECK_EN adds a sticky pc_misalign output and word-aligns every loaded PC.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_pc,
  input  logic        pc_src,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic        pc_misalign
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN,
    HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpp4_q, ifpp4_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] pc_load;

  logic pc_ld_next, pc_ld_tgt, ifid_ld_mem, ifid_ld_buf, ifid_clr, buf_ld, tgt_ld;

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign pc_load = {next_pc[31:2], 2'b00};
`else
  assign pc_load = next_pc;
`endif

  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = REQ;
      REQ: begin
        if (imem_ack) state_d = (!pc_src && stall) ? HOLD : REQ;
        else if (pc_src) state_d = DRAIN;
      end
      DRAIN: if (imem_ack) state_d = REQ;
      HOLD:  if (pc_src || !stall) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    pc_ld_next  = 1'b0;
    pc_ld_tgt   = 1'b0;
    ifid_ld_mem = 1'b0;
    ifid_ld_buf = 1'b0;
    ifid_clr    = 1'b0;
    buf_ld      = 1'b0;
    tgt_ld      = 1'b0;
    unique case (state_q)
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (pc_src) begin
            pc_ld_next = 1'b1;
            ifid_clr   = 1'b1;
          end else if (stall) begin
            buf_ld = 1'b1;
          end else begin
            ifid_ld_mem = 1'b1;
            pc_ld_next  = 1'b1;
          end
        end else if (pc_src) begin
          tgt_ld   = 1'b1;
          ifid_clr = 1'b1;
        end else if (!stall) begin
          ifid_clr = 1'b1;
        end
      end
      // The old request is still in flight; its response is dropped and the target takes over.
      DRAIN: begin
        imem_req = 1'b1;
        if (imem_ack) pc_ld_tgt = 1'b1;
      end
      HOLD: begin
        if (pc_src) begin
          pc_ld_next = 1'b1;
          ifid_clr   = 1'b1;
        end else if (!stall) begin
          ifid_ld_buf = 1'b1;
          pc_ld_next  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ifpp4_d = ifpp4_q;
    buf_d   = buf_q;
    tgt_d   = tgt_q;
    if (pc_ld_next) pc_d = pc_load;
    if (pc_ld_tgt)  pc_d = tgt_q;
    if (tgt_ld)     tgt_d = pc_load;
    if (buf_ld)     buf_d = imem_rdata;
    if (ifid_clr)   valid_d = 1'b0;
    if (ifid_ld_mem || ifid_ld_buf) begin
      valid_d = 1'b1;
      instr_d = ifid_ld_mem ? imem_rdata : buf_q;
      ifpp4_d = pc_plus4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      ifpp4_q <= '0;
      buf_q   <= '0;
      tgt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpp4_q <= ifpp4_d;
      buf_q   <= buf_d;
      tgt_q   <= tgt_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // Flagged when next_pc is captured, whether loaded directly or latched as a redirect target.
  assign misalign_d = misalign_q | ((pc_ld_next | tgt_ld) & (next_pc[1:0] != 2'b00));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end

  assign pc_misalign = misalign_q;
`endif

  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign if_id_valid    = valid_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = ifpp4_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a transaction-level fetch model checked every cycle,
// plus hand-computed literal expectations; a second instance covers RESET_PC wrap-around.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] next_pc = '0;
  logic        pc_src = 1'b0;
  logic        stall = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr, pc, pc_plus4, if_id_instr, if_id_pc_plus4;
  logic        if_id_valid;

  logic [31:0] w_next_pc = '0;
  logic        w_ack = 1'b0;
  logic [31:0] w_rdata = '0;
  logic        w_zero = 1'b0;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_pc, w_pp4, w_instr, w_ifpp4;

`ifdef PC_ALIGN_CHECK_EN
  logic pc_misalign, w_misalign;
`endif

  int  checks = 0;
  int  passed = 0;
  bit  run = 1'b0;

  always #5 clk = ~clk;

  fetch_pc_unit dut (
    .clk(clk), .reset(reset), .next_pc(next_pc), .pc_src(pc_src), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(pc), .pc_plus4(pc_plus4), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4)
`ifdef PC_ALIGN_CHECK_EN
    , .pc_misalign(pc_misalign)
`endif
  );

  fetch_pc_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset), .next_pc(w_next_pc), .pc_src(w_zero), .stall(w_zero),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
    .pc(w_pc), .pc_plus4(w_pp4), .if_id_valid(w_valid), .if_id_instr(w_instr),
    .if_id_pc_plus4(w_ifpp4)
`ifdef PC_ALIGN_CHECK_EN
    , .pc_misalign(w_misalign)
`endif
  );

  // Model: is the fetcher started, is a response owed but unwanted, is a word parked.
  bit          m_live, m_drain, m_held, m_valid;
  logic [31:0] m_pc, m_instr, m_pp4, m_buf, m_tgt;

  function automatic logic [31:0] fix(input logic [31:0] a);
`ifdef PC_ALIGN_CHECK_EN
    return a & 32'hFFFF_FFFC;
`else
    return a;
`endif
  endfunction

  task automatic deliver(input logic [31:0] word);
    m_valid = 1'b1;
    m_instr = word;
    m_pp4   = m_pc + 32'd4;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_live = 0; m_drain = 0; m_held = 0; m_valid = 0;
      m_pc = 32'h0; m_instr = 0; m_pp4 = 0; m_buf = 0; m_tgt = 0;
    end else if (!m_live) begin
      m_live = 1;
    end else if (m_held) begin
      if (pc_src) begin
        m_held = 0; m_valid = 0; m_pc = fix(next_pc);
      end else if (!stall) begin
        m_held = 0; deliver(m_buf); m_pc = fix(next_pc);
      end
    end else if (m_drain) begin
      if (imem_ack) begin
        m_drain = 0; m_pc = m_tgt;
      end
    end else if (imem_ack) begin
      if (pc_src) begin
        m_valid = 0; m_pc = fix(next_pc);
      end else if (stall) begin
        m_buf = imem_rdata; m_held = 1;
      end else begin
        deliver(imem_rdata); m_pc = fix(next_pc);
      end
    end else if (pc_src) begin
      m_tgt = fix(next_pc); m_drain = 1; m_valid = 0;
    end else if (!stall) begin
      m_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      logic [31:0] e_req;
      e_req = {31'd0, m_live && !m_held};
      checks++;
      if (imem_req === e_req[0] && imem_addr === m_pc && pc === m_pc &&
          pc_plus4 === m_pc + 32'd4 && if_id_valid === m_valid &&
          if_id_instr === m_instr && if_id_pc_plus4 === m_pp4)
        passed++;
      else
        $display("FAIL cycle@%0t got req=%b addr=%h pc=%h pp4=%h v=%b ins=%h ipp4=%h expected req=%b pc=%h pp4=%h v=%b ins=%h ipp4=%h",
                 $time, imem_req, imem_addr, pc, pc_plus4, if_id_valid, if_id_instr, if_id_pc_plus4,
                 e_req[0], m_pc, m_pc + 32'd4, m_valid, m_instr, m_pp4);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step(input logic ack, input logic [31:0] rd, input logic src,
                      input logic stl, input logic [31:0] np);
    imem_ack   = ack;
    imem_rdata = rd;
    pc_src     = src;
    stall      = stl;
    next_pc    = np;
    @(posedge clk);
    #1;
  endtask

  task automatic seq(input logic ack, input logic [31:0] rd, input logic stl);
    step(ack, rd, 1'b0, stl, m_pc + 32'd4);
  endtask

  initial begin
    #1 reset = 1'b1;
    run = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_pc", pc, 32'h0);
    chk("reset_req", {31'd0, imem_req}, 32'd0);
    chk("reset_valid", {31'd0, if_id_valid}, 32'd0);
    chk("wrap_reset_pc", w_pc, 32'hFFFF_FFFC);
    chk("wrap_reset_pp4", w_pp4, 32'h0);

    seq(1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("idle_ack_ignored", {31'd0, if_id_valid}, 32'd0);
    chk("first_addr", imem_addr, 32'h0);
    w_ack = 1'b1; w_rdata = 32'h0000_C0DE; w_next_pc = 32'h0;

    seq(1'b1, 32'd0, 1'b0);
    w_ack = 1'b0;
    chk("wrap_pc", w_pc, 32'h0);
    chk("wrap_ifpp4", w_ifpp4, 32'h0);
    chk("wrap_instr", w_instr, 32'h0000_C0DE);
    chk("i0_pp4", if_id_pc_plus4, 32'h4);

    seq(1'b1, 32'd1, 1'b0);
    chk("i1_pc", pc, 32'h8);
    chk("i1_instr", if_id_instr, 32'd1);

    seq(1'b1, 32'hAAAA_0002, 1'b1);
    seq(1'b1, 32'h0000_0BAD, 1'b1);
    seq(1'b0, 32'd0, 1'b1);
    chk("hold_pc", pc, 32'h8);
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    chk("hold_frozen", if_id_instr, 32'd1);
    seq(1'b0, 32'd0, 1'b0);
    chk("unhold_instr", if_id_instr, 32'hAAAA_0002);
    chk("unhold_pp4", if_id_pc_plus4, 32'd12);
    chk("unhold_pc", pc, 32'd12);

    seq(1'b0, 32'd0, 1'b0);
    seq(1'b1, 32'd5, 1'b0);

    step(1'b1, 32'h77, 1'b1, 1'b0, 32'h40);
    chk("redir_valid", {31'd0, if_id_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'h40);
    seq(1'b1, 32'd6, 1'b0);
    chk("after_redir_pp4", if_id_pc_plus4, 32'h44);
    seq(1'b0, 32'd0, 1'b1);
    step(1'b1, 32'h99, 1'b1, 1'b1, 32'h60);
    chk("src_over_stall", pc, 32'h60);

    step(1'b0, 32'd0, 1'b1, 1'b0, 32'h80);
    step(1'b0, 32'd0, 1'b1, 1'b1, 32'h200);
    chk("drain_addr", imem_addr, 32'h60);
    chk("drain_req", {31'd0, imem_req}, 32'd1);
    seq(1'b1, 32'h55, 1'b0);
    chk("drain_pc", pc, 32'h80);
    chk("drain_discard", {31'd0, if_id_valid}, 32'd0);
    seq(1'b1, 32'd7, 1'b0);

    seq(1'b1, 32'd8, 1'b1);
    step(1'b0, 32'd0, 1'b1, 1'b1, 32'h100);
    chk("hold_redir_pc", pc, 32'h100);

    step(1'b1, 32'd9, 1'b0, 1'b0, 32'h102);
`ifdef PC_ALIGN_CHECK_EN
    chk("align_pc", pc, 32'h100);
    chk("align_flag", {31'd0, pc_misalign}, 32'd1);
`else
    chk("noalign_pc", pc, 32'h102);
`endif
    seq(1'b1, 32'd10, 1'b0);

    imem_ack = 1'b1;
    reset = 1'b1;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_valid", {31'd0, if_id_valid}, 32'd0);
    chk("async_req", {31'd0, imem_req}, 32'd0);
`ifdef PC_ALIGN_CHECK_EN
    chk("align_clear", {31'd0, pc_misalign}, 32'd0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    step(1'b1, 32'h0000_0BAD, 1'b0, 1'b0, 32'h500);
    chk("stale_ack_pc", pc, 32'h0);
    chk("stale_ack_valid", {31'd0, if_id_valid}, 32'd0);
    seq(1'b1, 32'd11, 1'b0);
    chk("post_reset_instr", if_id_instr, 32'd11);
    seq(1'b0, 32'd0, 1'b0);
    @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
